bus_arbiter_4: RTL and testbench

BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

---
 rtl/bus_arbiter_4.sv | 131 +++++++++++++
 tb/tb_bus_arbiter_4.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_4.sv
// Four-requester round-robin bus arbiter with a bounded hold time.
// An owner keeps the bus while it requests, and is forced off after max_hold cycles when others wait.
module bus_arbiter_4 #(
    parameter int unsigned width    = 32,
    parameter int unsigned max_hold = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [width-1:0] data_0,
    input  logic [width-1:0] data_1,
    input  logic [width-1:0] data_2,
    input  logic [width-1:0] data_3,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic             valid,
    output logic [width-1:0] data_out
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [7:0] HoldLast = 8'(max_hold - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;

    logic [3:0] owner_oh;
    logic [3:0] others;
    logic [2:0] pick;
    logic       release_now;

    // Returns {found, index}: first set bit of cand scanning upward from start, mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!res[2] && cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        valid_d     = valid_q;
        owner_oh    = 4'(1) << owner_q;
        others      = req & ~owner_oh;
        pick        = 3'b000;
        release_now = 1'b0;

        unique case (state_q)
            StIdle: begin
                pick = rr_pick(req, ptr_q);
                if (pick[2]) begin
                    state_d = StBusy;
                    owner_d = pick[1:0];
                    grant_d = 4'(1) << pick[1:0];
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            StBusy: begin
                release_now = !req[owner_q] || ((cnt_q == HoldLast) && (|others));
                if (release_now) begin
                    ptr_d = owner_q + 2'd1;
                    // The releasing owner is masked so it cannot immediately win again.
                    pick  = rr_pick(others, ptr_d);
                    if (pick[2]) begin
                        owner_d = pick[1:0];
                        grant_d = 4'(1) << pick[1:0];
                        valid_d = 1'b1;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign grant  = grant_q;
    assign select = owner_q;
    assign valid  = valid_q;

    always_comb begin
        data_out = '0;
        if (valid_q) begin
            unique case (owner_q)
                2'd0:    data_out = data_0;
                2'd1:    data_out = data_1;
                2'd2:    data_out = data_2;
                default: data_out = data_3;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4: one task per scenario, with structural checks on every cycle.
module tb_bus_arbiter_4;

    localparam int unsigned Width = 32;

    logic             clk;
    logic             reset;
    logic [3:0]       req;
    logic [Width-1:0] data_0, data_1, data_2, data_3;
    logic [3:0]       grant;
    logic [1:0]       select;
    logic             valid;
    logic [Width-1:0] data_out;

    int n_cmp;
    int n_bad;

    bus_arbiter_4 #(.width(Width), .max_hold(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_0   (data_0),
        .data_1   (data_1),
        .data_2   (data_2),
        .data_3   (data_3),
        .grant    (grant),
        .select   (select),
        .valid    (valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, sample 1ns after the edge and check the structural invariants.
    task automatic tick();
        logic [3:0] sel_oh;
        @(posedge clk);
        #1;
        n_cmp++;
        if ((grant & (grant - 4'd1)) !== 4'b0000) begin
            n_bad++;
            $display("FAIL onehot0: grant=%b required one-hot or zero", grant);
        end
        n_cmp++;
        if (valid !== (|grant)) begin
            n_bad++;
            $display("FAIL valid_vs_grant: valid=%b required %b", valid, |grant);
        end
        if (valid === 1'b1) begin
            sel_oh = 4'(1) << select;
            n_cmp++;
            if (grant !== sel_oh) begin
                n_bad++;
                $display("FAIL select_vs_grant: grant=%b required %b (select=%0d)",
                         grant, sel_oh, select);
            end
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = 4'b0000;
        data_0 = 32'h1111_0000;
        data_1 = 32'h2222_0001;
        data_2 = 32'hDEAD_BEEF;
        data_3 = 32'h4444_0003;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++; $display("FAIL reset_grant: got %b required 0000", grant);
        end
        n_cmp++;
        if (select !== 2'd0) begin
            n_bad++; $display("FAIL reset_select: got %0d required 0", select);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b required 0", valid);
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h required 0", data_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        n_cmp++;
        if (grant !== 4'b0100 || select !== 2'd2 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: grant=%b sel=%0d valid=%b required 0100/2/1",
                     grant, select, valid);
        end
        n_cmp++;
        if (data_out !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL single_data: got %h required deadbeef", data_out);
        end
        for (int i = 0; i < 22; i++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0100) begin
                n_bad++; $display("FAIL single_hold cycle %0d: got %b required 0100", i, grant);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] req_seq [5];
        logic [3:0] exp_seq [5];
        logic [31:0] exp_dat [5];
        req_seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1001, 4'b0001};
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003, 32'h1111_0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = req_seq[i];
            tick();
            n_cmp++;
            if (grant !== exp_seq[i]) begin
                n_bad++; $display("FAIL rr_grant step %0d: got %b required %b", i, grant, exp_seq[i]);
            end
            n_cmp++;
            if (data_out !== exp_dat[i]) begin
                n_bad++;
                $display("FAIL rr_data step %0d: got %h required %h", i, data_out, exp_dat[i]);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_forced();
        do_reset();
        req = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0010) begin
                n_bad++; $display("FAIL forced_hold cycle %0d: got %b required 0010", i, grant);
            end
        end
        tick();
        n_cmp++;
        if (grant !== 4'b1000 || select !== 2'd3) begin
            n_bad++; $display("FAIL forced_handoff: got %b sel=%0d required 1000/3", grant, select);
        end
        n_cmp++;
        if (dut.ptr_q !== 2'd2) begin
            n_bad++; $display("FAIL forced_ptr: got %0d required 2", dut.ptr_q);
        end
        for (int i = 0; i < 7; i++) tick();
        tick();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++; $display("FAIL forced_back: got %b required 0010", grant);
        end
    endtask

    task automatic test_idle_wrap();
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || valid !== 1'b0 || select !== 2'd3) begin
            n_bad++;
            $display("FAIL idle_release: grant=%b valid=%b sel=%0d required 0000/0/3",
                     grant, valid, select);
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_bad++; $display("FAIL idle_data: got %h required 0", data_out);
        end
        req = 4'b0011;
        tick();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++; $display("FAIL idle_wrap_grant: got %b required 0001", grant);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0110;
        tick();
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_bad++; $display("FAIL mid_pre: got %b required 0100", grant);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (grant !== 4'b0000 || select !== 2'd0 || data_out !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset: grant=%b sel=%0d data=%h required 0000/0/0",
                     grant, select, data_out);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++; $display("FAIL mid_after: got %b required 0010", grant);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0011;
        tick();
        req = 4'b0001;
        tick();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++; $display("FAIL withdraw_hold: got %b required 0001", grant);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++; $display("FAIL withdraw_idle: got %b required 0000", grant);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        data_0 = '0;
        data_1 = '0;
        data_2 = '0;
        data_3 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_forced();
        test_idle_wrap();
        test_reset_mid();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
